// File: rtl/response_framer_if.sv
// Response-frame push channel between the response logic (master) and the framer (slave).
interface response_framer_if;
    logic       RespValid;
    logic [7:0] RespCode;
    logic [7:0] RespData;
    logic       RespReady;

    modport master (
        output RespValid,
        output RespCode,
        output RespData,
        input  RespReady
    );

    modport slave (
        input  RespValid,
        input  RespCode,
        input  RespData,
        output RespReady
    );
endinterface

// File: rtl/response_framer.sv
// Buffers 2-byte response frames in a small FIFO and serializes them to a UART
// transmitter, code byte first, with a per-byte TxDone watchdog.
module response_framer #(
    parameter int DEPTH_LOG2 = 2,
    parameter int TIMEOUT    = 100000
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    response_framer_if.slave      resp,
    output logic [7:0]            TxData,
    output logic                  TxEn,
    input  logic                  TxDone,
    output logic                  Busy,
    output logic [DEPTH_LOG2:0]   Level,
    output logic                  Overflow,
    output logic                  TxErr,
    output logic [7:0]            FrameCnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WD_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = DEPTH_LOG2'(0);
    localparam logic [WD_W-1:0]       WD_LIMIT   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]       WD_ONE     = WD_W'(1);
    localparam logic [WD_W-1:0]       WD_ZERO    = WD_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND_HI = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_POP     = 3'd5,
        ST_ABORT   = 3'd6
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;

    logic [15:0]             mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_r;
    logic [DEPTH_LOG2-1:0]   rd_ptr_r;
    logic [DEPTH_LOG2:0]     level_r;
    logic [15:0]             head_s;
    logic                    ready_s;
    logic                    push_s;
    logic                    pop_s;

    logic                    txd_q_r;
    logic                    txd_rise_s;
    logic [WD_W-1:0]         wd_r;
    logic                    wd_expired_s;

    logic [7:0]              tx_data_r;
    logic                    tx_en_r;
    logic                    busy_r;
    logic                    overflow_r;
    logic                    tx_err_r;
    logic [7:0]              frame_cnt_r;

    // Ready is judged on start-of-cycle occupancy, so a same-cycle pop never frees room for a push
    assign ready_s        = (level_r != FULL_LEVEL);
    assign push_s         = resp.RespValid & ready_s;
    assign pop_s          = (state_r == ST_POP) || (state_r == ST_ABORT);
    assign head_s         = mem_r[rd_ptr_r];
    assign txd_rise_s     = TxDone & ~txd_q_r;
    assign wd_expired_s   = (wd_r >= WD_LIMIT);

    assign resp.RespReady = ready_s;
    assign TxData         = tx_data_r;
    assign TxEn           = tx_en_r;
    assign Busy           = busy_r;
    assign Level          = level_r;
    assign Overflow       = overflow_r;
    assign TxErr          = tx_err_r;
    assign FrameCnt       = frame_cnt_r;

    // Frame storage: {code, data} written at the write pointer
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {resp.RespCode, resp.RespData};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally; a simultaneous push and pop leave the level unchanged
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LEVEL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // TxDone history for rising-edge detection
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            txd_q_r <= 1'b0;
        end else begin
            txd_q_r <= TxDone;
        end
    end

    // Watchdog: cleared when a byte is launched, counts only while waiting, saturates at the limit
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wd_r <= WD_ZERO;
        end else begin
            case (state_r)
                ST_SEND_HI, ST_SEND_LO: wd_r <= WD_ZERO;
                ST_WAIT_HI, ST_WAIT_LO: begin
                    if (wd_r < WD_LIMIT) begin
                        wd_r <= wd_r + WD_ONE;
                    end else begin
                        wd_r <= wd_r;
                    end
                end
                default:                wd_r <= wd_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state; a TxDone rise takes priority over a same-cycle timeout
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (level_r != LEVEL_ZERO) begin
                    next_state_s = ST_SEND_HI;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND_HI: next_state_s = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (txd_rise_s) begin
                    next_state_s = ST_SEND_LO;
                end else if (wd_expired_s) begin
                    next_state_s = ST_ABORT;
                end else begin
                    next_state_s = ST_WAIT_HI;
                end
            end
            ST_SEND_LO: next_state_s = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (txd_rise_s) begin
                    next_state_s = ST_POP;
                end else if (wd_expired_s) begin
                    next_state_s = ST_ABORT;
                end else begin
                    next_state_s = ST_WAIT_LO;
                end
            end
            ST_POP:     next_state_s = ST_IDLE;
            ST_ABORT:   next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so TxEn/TxErr/Busy coincide with their states
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            tx_data_r   <= 8'h00;
            tx_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
            tx_err_r    <= 1'b0;
            frame_cnt_r <= 8'h00;
        end else begin
            tx_en_r    <= (next_state_s == ST_SEND_HI) || (next_state_s == ST_SEND_LO);
            busy_r     <= (next_state_s != ST_IDLE);
            tx_err_r   <= (next_state_s == ST_ABORT);
            overflow_r <= resp.RespValid & ~ready_s;
            case (next_state_s)
                ST_SEND_HI: tx_data_r <= head_s[15:8];
                ST_SEND_LO: tx_data_r <= head_s[7:0];
                default:    tx_data_r <= tx_data_r;
            endcase
            if (state_r == ST_POP) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_response_framer.sv
// Scoreboard bench for response_framer: expected bytes are queued at push time
// and matched against bytes captured on each TxEn pulse.
module tb_response_framer;

    localparam int TMO = 60;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       busy;
    logic [2:0] level;
    logic       overflow;
    logic       tx_err;
    logic [7:0] frame_cnt;
    logic       done_auto   = 1'b0;
    logic       done_manual = 1'b0;
    logic       tx_done;
    bit         auto_done   = 1'b0;
    int         dly  = 0;
    int         hold = 0;
    int         cyc  = 0;
    int         n_cmp  = 0;
    int         n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_cyc[$];

    response_framer_if rif();

    assign tx_done = done_auto | done_manual;

    response_framer #(.DEPTH_LOG2(2), .TIMEOUT(TMO)) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .resp     (rif),
        .TxData   (tx_data),
        .TxEn     (tx_en),
        .TxDone   (tx_done),
        .Busy     (busy),
        .Level    (level),
        .Overflow (overflow),
        .TxErr    (tx_err),
        .FrameCnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // capture every transmitted byte with its cycle stamp
    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            obs_q.push_back(tx_data);
            obs_cyc.push_back(cyc);
        end
    end

    // UART model: TxDone rises 20 cycles after each TxEn, held 3 cycles
    always @(negedge clk) begin
        if (!auto_done) begin
            done_auto = 1'b0; dly = 0; hold = 0;
        end else if (tx_en === 1'b1) begin
            done_auto = 1'b0; dly = 20; hold = 0;
        end else if (dly > 0) begin
            dly = dly - 1;
            if (dly == 0) begin done_auto = 1'b1; hold = 3; end
        end else if (hold > 0) begin
            hold = hold - 1;
            if (hold == 0) done_auto = 1'b0;
        end
    end

    task automatic push_frame(input logic [7:0] c, input logic [7:0] d, input bit want, output bit acc);
        rif.RespValid = 1'b1;
        rif.RespCode  = c;
        rif.RespData  = d;
        acc = rif.RespReady;
        if (want) begin exp_q.push_back(c); exp_q.push_back(d); end
        @(negedge clk);
        rif.RespValid = 1'b0;
    endtask

    task automatic wait_obs(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (obs_q.size() > 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok && obs_q.size() > 0) ok = 1'b1;
    endtask

    function automatic logic [23:0] out_vec();
        return {tx_data, tx_en, busy, level, overflow, tx_err, frame_cnt, rif.RespReady};
    endfunction

    localparam logic [23:0] RESET_VEC = {8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1};

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_values: got %h want %h", out_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL idle_after_reset: got %h want %h", out_vec(), RESET_VEC);
        end
    endtask

    task automatic test_single();
        bit ok, acc; int p, a, b; logic [7:0] o, e;
        auto_done = 1'b1;
        p = cyc;
        push_frame(8'h00, 8'h1F, 1'b1, acc);
        wait_obs(100, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL single_first: no TxEn, want %h", e); a = cyc; end
        else begin
            o = obs_q.pop_front(); a = obs_cyc.pop_front();
            if (o !== e || a !== p + 2) begin
                n_fail++; $display("FAIL single_first: got %h@%0d want %h@%0d", o, a, e, p + 2);
            end
        end
        wait_obs(100, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL single_second: no TxEn, want %h", e); b = cyc; end
        else begin
            o = obs_q.pop_front(); b = obs_cyc.pop_front();
            if (o !== e || b !== a + 21) begin
                n_fail++; $display("FAIL single_second: got %h@%0d want %h@%0d", o, b, e, a + 21);
            end
        end
        while (cyc < b + 21) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_pop: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || frame_cnt !== 8'd1) begin
            n_fail++; $display("FAIL single_done: busy %b cnt %0d want 0 / 1", busy, frame_cnt);
        end
    endtask

    task automatic test_overflow();
        bit ok, acc; int cnt; logic [7:0] o, e;
        auto_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_frame(8'(8'h10 + i), 8'(8'h20 + i), (i < 4), acc);
            n_cmp++;
            if (acc !== (i < 4)) begin
                n_fail++; $display("FAIL ovf_ready_%0d: got %b want %b", i, acc, (i < 4));
            end
        end
        n_cmp++;
        if (level !== 3'd4 || rif.RespReady !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full: level %0d ready %b want 4 / 0", level, rif.RespReady);
        end
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (overflow === 1'b1) cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt !== 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 1", cnt); end
        auto_done = 1'b1;
        done_manual = 1'b1;
        @(negedge clk);
        done_manual = 1'b0;
        while (exp_q.size() > 0) begin
            wait_obs(200, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL ovf_drain: no byte, want %h", e); exp_q.delete(); end
            else begin
                o = obs_q.pop_front(); void'(obs_cyc.pop_front());
                if (o !== e) begin n_fail++; $display("FAIL ovf_drain: got %h want %h", o, e); end
            end
        end
        repeat (60) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || frame_cnt !== 8'd5 || level !== 3'd0) begin
            n_fail++; $display("FAIL ovf_dropped: extra %0d cnt %0d level %0d want 0 / 5 / 0",
                               obs_q.size(), frame_cnt, level);
        end
    endtask

    task automatic test_order_wrap();
        bit ok, acc; logic [7:0] o, e;
        auto_done = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            for (int k = 0; k < 500; k++) begin
                if (rif.RespReady === 1'b1) break;
                @(negedge clk);
            end
            push_frame(8'(i), 8'(8'hB0 + i), 1'b1, acc);
        end
        while (exp_q.size() > 0) begin
            wait_obs(200, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL order: no byte, want %h", e); exp_q.delete(); end
            else begin
                o = obs_q.pop_front(); void'(obs_cyc.pop_front());
                if (o !== e) begin n_fail++; $display("FAIL order: got %h want %h", o, e); end
            end
        end
        repeat (25) @(negedge clk);
        n_cmp++;
        if (frame_cnt !== 8'd15 || level !== 3'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL order_end: cnt %0d level %0d busy %b want 15 / 0 / 0",
                               frame_cnt, level, busy);
        end
    endtask

    task automatic test_watchdog();
        bit ok, acc; int a, t, cnt; logic [7:0] o;
        auto_done = 1'b0;
        push_frame(8'h55, 8'hAA, 1'b1, acc);
        void'(exp_q.pop_back());
        wait_obs(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL wd_first: no TxEn want 55"); a = cyc; end
        else begin
            o = obs_q.pop_front(); a = obs_cyc.pop_front(); void'(exp_q.pop_front());
            if (o !== 8'h55) begin n_fail++; $display("FAIL wd_first: got %h want 55", o); end
        end
        t = -1;
        for (int k = 0; k < 200; k++) begin
            if (tx_err === 1'b1) begin t = cyc; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (t !== a + TMO + 2) begin n_fail++; $display("FAIL wd_time: got %0d want %0d", t, a + TMO + 2); end
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_err === 1'b1) cnt++;
        end
        n_cmp++;
        if (cnt !== 0 || level !== 3'd0 || frame_cnt !== 8'd15 || busy !== 1'b0 || obs_q.size() !== 0) begin
            n_fail++; $display("FAIL wd_after: extra_err %0d level %0d cnt %0d busy %b bytes %0d want 0/0/15/0/0",
                               cnt, level, frame_cnt, busy, obs_q.size());
        end
    endtask

    task automatic test_stale_done();
        bit ok, acc; int r, s; logic [7:0] o;
        auto_done = 1'b0;
        done_manual = 1'b1;
        repeat (3) @(negedge clk);
        push_frame(8'h33, 8'h44, 1'b1, acc);
        wait_obs(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL stale_first: no TxEn want 33"); end
        else begin
            o = obs_q.pop_front(); void'(obs_cyc.pop_front()); void'(exp_q.pop_front());
            if (o !== 8'h33) begin n_fail++; $display("FAIL stale_first: got %h want 33", o); end
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || obs_q.size() !== 0) begin
            n_fail++; $display("FAIL stale_hold: busy %b bytes %0d want 1 / 0", busy, obs_q.size());
        end
        done_manual = 1'b0;
        repeat (2) @(negedge clk);
        done_manual = 1'b1;
        r = cyc;
        @(negedge clk);
        wait_obs(20, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL stale_second: no TxEn want 44"); end
        else begin
            o = obs_q.pop_front(); s = obs_cyc.pop_front(); void'(exp_q.pop_front());
            if (o !== 8'h44 || s !== r + 1) begin
                n_fail++; $display("FAIL stale_second: got %h@%0d want 44@%0d", o, s, r + 1);
            end
        end
        done_manual = 1'b0;
        @(negedge clk);
        done_manual = 1'b1;
        @(negedge clk);
        done_manual = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (frame_cnt !== 8'd16 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stale_end: cnt %0d busy %b want 16 / 0", frame_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, acc; logic [7:0] o, e;
        auto_done = 1'b1;
        push_frame(8'h61, 8'h71, 1'b1, acc);
        push_frame(8'h62, 8'h72, 1'b1, acc);
        push_frame(8'h63, 8'h73, 1'b1, acc);
        for (int i = 0; i < 2; i++) begin
            wait_obs(100, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL rstmid_byte%0d: no TxEn want %h", i, e); end
            else begin
                o = obs_q.pop_front(); void'(obs_cyc.pop_front());
                if (o !== e) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h want %h", i, o, e); end
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL rstmid_values: got %h want %h", out_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        exp_q.delete();
        repeat (100) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || busy !== 1'b0 || level !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_quiet: bytes %0d busy %b level %0d want 0 / 0 / 0",
                               obs_q.size(), busy, level);
        end
    endtask

    initial begin
        rif.RespValid = 1'b0;
        rif.RespCode  = 8'h00;
        rif.RespData  = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_order_wrap();
        test_watchdog();
        test_stale_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: run did not complete, compared %0d", n_cmp);
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/response_framer.md
# response_framer

Transmit-side counterpart of `protocol_control`. It accepts 2-byte response frames (response code, data byte) from the response logic. It buffers them in a small FIFO and serializes each frame onto `UART_tx` as two consecutive bytes, code first. It paces the bytes with the `TxEn`/`TxDone` handshake and recovers from a stalled transmitter with a watchdog.

## Interface
Parameters:
- `DEPTH_LOG2`, default 2: the FIFO holds 2^DEPTH_LOG2 frames (default 4).
- `TIMEOUT`, default 100000: the maximum number of cycles to wait for `TxDone` per byte. One byte at 9600 baud and 50 MHz takes about 52083 cycles.

Ports:
- `Clk`, in, 1: the single clock. All logic is on the rising edge.
- `Rst_n`, in, 1: synchronous active-low reset.
- `RespValid`, in, 1: push request for one frame.
- `RespCode`, in, 8: first byte on the wire.
- `RespData`, in, 8: second byte on the wire.
- `RespReady`, out, 1: FIFO not full. Combinational from the occupancy count.
- `TxData`, out, 8: byte to `UART_tx`. Registered.
- `TxEn`, out, 1: one-cycle start pulse to `UART_tx`. Registered.
- `TxDone`, in, 1: completion flag from `UART_tx`. Only its rising edge is used.
- `Busy`, out, 1: high whenever the FSM is not in IDLE.
- `Level`, out, DEPTH_LOG2+1: FIFO occupancy.
- `Overflow`, out, 1: one-cycle pulse when a push is rejected.
- `TxErr`, out, 1: one-cycle pulse on a watchdog abort.
- `FrameCnt`, out, 8: count of frames completed. Wraps from 255 to 0.

## Operation
FIFO:
- A push is accepted iff `RespValid` and `RespReady` are both high. The frame {code, data} is written at the write pointer.
- If `RespValid` is high while the FIFO is full, the frame is dropped and `Overflow` pulses in the next cycle.
- `RespReady` reflects the occupancy at the start of the cycle. A pop in the same cycle as a push does not make room for that push.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally.
- A pop and a push in the same cycle leave `Level` unchanged.

Edge detect: `txd_rise` is `TxDone & ~TxDone_q`, where `TxDone_q` is `TxDone` registered. A `TxDone` that is already high when a wait state is entered does not count.

FSM states:
- IDLE: if `Level` is nonzero, go to SEND_HI.
- SEND_HI: `TxData` takes the head code, `TxEn` is 1 for this cycle only, the watchdog is cleared, and the FSM goes to WAIT_HI.
- WAIT_HI: on `txd_rise`, go to SEND_LO. If the watchdog reaches `TIMEOUT`, go to ABORT.
- SEND_LO: `TxData` takes the head data byte, `TxEn` is 1 for this cycle, the watchdog is cleared, and the FSM goes to WAIT_LO.
- WAIT_LO: on `txd_rise`, go to POP. If the watchdog reaches `TIMEOUT`, go to ABORT.
- POP: pop the head, increment `FrameCnt`, and return to IDLE.
- ABORT: pop the head without incrementing `FrameCnt`, pulse `TxErr`, and return to IDLE. The remainder of the aborted frame is never sent.

Other rules:
- `TxData` holds its last value from SEND_x until the next SEND_x.
- The watchdog is a counter of ceil(log2(TIMEOUT+1)) bits. It increments only in WAIT_x and saturates.
- If `txd_rise` and the timeout occur in the same cycle, `txd_rise` wins.

## Timing
- Reset values: `TxData`=0, `TxEn`=0, `Busy`=0, `Level`=0, `Overflow`=0, `TxErr`=0, `FrameCnt`=0, `RespReady`=1. Pointers and the watchdog are 0 and the FSM is in IDLE.
- Reset asserted mid-frame returns to IDLE on that edge. All buffered frames are discarded. A byte already being shifted out by `UART_tx` is not aborted by this block.
- Push to first byte: with the FIFO empty and the FSM idle, a push sampled at edge N gives `TxEn`=1 in cycle N+2: the FIFO write lands at N+1 and SEND_HI is registered at N+2.
- Byte to byte: if `txd_rise` is sampled at edge M in WAIT_HI, the second `TxEn` is high in cycle M+1.
- Frame to frame: a `txd_rise` in WAIT_LO at edge M is followed by POP at M+1, IDLE at M+2, and the next frame's `TxEn` at M+3.
- Every frame produces exactly two `TxEn` pulses, unless it is aborted.
- Minimum spacing between two `TxEn` pulses is 2 cycles.

## Test plan
- Single frame: push {0x00, 0x1F} into an empty FIFO, with a bench model that raises `TxDone` 20 cycles after each `TxEn`. Required: `TxEn` at N+2 with `TxData`=0x00, then `TxEn` with `TxData`=0x1F one cycle after the first `TxDone` rise, `FrameCnt`=1, `Busy` low 2 cycles after the second rise.
- Fill and overflow: push 5 frames back-to-back with `TxDone` held low. Required: `Level`=4, `RespReady`=0, exactly one `Overflow` pulse, and the 5th frame never transmitted.
- Ordering and wrap: stream 10 frames with codes 0x01 to 0x0A through the depth-4 FIFO. Required: the bytes appear in order, pointers wrap, and `FrameCnt`=10.
- Watchdog: push one frame and never raise `TxDone`. Required: `TxErr` pulses once TIMEOUT+2 cycles after `TxEn`, `Level`=0, `FrameCnt`=0, and the FSM is back in IDLE.
- Stale `TxDone`: hold `TxDone`=1 before the push. Required: the FSM stays in WAIT_HI until `TxDone` falls and rises again.
- Reset mid-frame: with 3 frames queued, assert `Rst_n`=0 in WAIT_LO for one cycle. Required: all outputs are at their reset values next cycle, and no further `TxEn` is issued.
